ext_sequencer: RTL and testbench
================================

Name: ext_sequencer

Overview:
- Instruction/data feeder and run controller for the 10-bit processor.
- Buffers host-written words in a circular queue and presents one word on the processor's external data bus each time the controller asserts Ext.
- Gates the timestep counter so the processor stalls on an empty queue.
- Supports run, single-instruction step and stop, and counts completed instructions.

Parameters:
- DEPTH, 16, queue entries (power of two).
- AW, 4, pointer width, log2(DEPTH).
- W, 10, word width; equals processor bus width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  host write strobe.
- wr_data  in  W  host word (instruction or LOAD operand).
- full  out  1  queue holds DEPTH words.
- count  out  AW+1  words currently queued.
- overflow  out  1  sticky; set by a write attempted while full.
- start  in  1  begin continuous execution.
- step  in  1  execute exactly one instruction.
- stop  in  1  pause execution.
- ext_req  in  1  processor controller Ext.
- clr_in  in  1  processor controller Clr (instruction complete).
- data_out  out  W  word driven to the processor data input.
- proc_en  out  1  enable for the processor timestep counter and IR/register clocks.
- busy  out  1  state is RUN or STEP.
- starved  out  1  processor waiting on an empty queue.
- instr_cnt  out  8  completed instructions; wraps 255 -> 0.

Behaviour:
- Reset values:
  - State IDLE.
  - wr_ptr = rd_ptr = 0, count = 0.
  - overflow = 0, instr_cnt = 0.
  - full = 0, proc_en = 0, busy = 0, starved = 0, data_out = 0.
  - Reset has priority over every other input and wins mid-instruction. The queue is emptied; the processor is stalled and must be reset separately.
- Queue:
  - Circular storage; full = (count == DEPTH), empty = (count == 0).
  - Write accepted when wr_en && !full: stores at wr_ptr, and wr_ptr increments modulo DEPTH.
  - wr_en && full: word dropped, overflow set.
  - A full queue rejects a write even when a consume occurs in the same cycle.
  - Consume: rd_ptr increments modulo DEPTH.
  - count updates by +1, -1, or 0 when a write and a consume occur together.
- Output and control equations:
  - data_out is combinational: mem[rd_ptr] when !empty, else 0.
  - starved = busy && ext_req && empty.
  - proc_en = busy && !starved.
  - consume = proc_en && ext_req. Every Ext cycle (T0 fetch, and T1 LOAD operand) pops exactly one word.
  - complete = proc_en && clr_in; instr_cnt increments on complete.
- FSM (command priority stop > start > step; commands are level-sampled each cycle):
  - IDLE: start -> RUN; else step -> STEP.
  - RUN: stop -> IDLE; start and step ignored.
  - STEP: stop -> IDLE; complete -> IDLE; start -> RUN (promotes the step).
- Timing of pause and resume:
  - Leaving RUN or STEP drops proc_en in the next cycle.
  - The processor freezes at its current T and resumes from that T on the next start or step. No word is lost or repeated.
- Starvation:
  - Stall holds until a word arrives.
  - A word written in cycle N is consumed no earlier than cycle N+1.
- The queue may be written in any state, including during execution.

Test Plan:
- Load 0x002, 0x0C0, 0x2A5 (ld R0; data 0x0C0 written as operand; addi R2,0x25), start; drive ext_req high on T0, high on T1 for the LOAD, and clr_in at T1 and T3 -> data_out sequence 0x002, 0x0C0, 0x2A5; count 3 -> 0; instr_cnt = 2; proc_en stays 1.
- Write 17 words with no start -> full = 1 and count = 16 after the 16th write; the 17th is dropped and overflow = 1. Then start and pop all 16 -> values match write order 0..15, and rd_ptr wraps to 0.
- Empty queue, start, ext_req = 1 -> starved = 1, proc_en = 0 indefinitely. Write 0x012 at cycle N -> proc_en = 1 and data_out = 0x012 at cycle N+1; consumed at that edge.
- Load two ADD instructions (0x012, 0x062); pulse step -> exactly one instruction executes; state returns to IDLE on its clr_in cycle; instr_cnt = 1; second word still queued with count = 1.
- RUN with stop asserted during T2 -> proc_en = 0 from the next cycle. Then start -> proc_en = 1; the processor finishes T3; instr_cnt increments once; no extra pop.
- rst asserted mid-instruction with count = 5 -> next cycle count = 0, state IDLE, proc_en = 0, instr_cnt = 0, overflow = 0.

Source files
------------

// File: rtl/ext_sequencer.sv
// Word queue and run controller feeding the 10-bit processor's external data bus.
// Pops one word per Ext cycle, stalls the processor on an empty queue, and counts completed instructions.
module ext_sequencer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int W     = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   output logic          full,
   output logic [AW:0]   count,
   output logic          overflow,
   input  logic          start,
   input  logic          step,
   input  logic          stop,
   input  logic          ext_req,
   input  logic          clr_in,
   output logic [W-1:0]  data_out,
   output logic          proc_en,
   output logic          busy,
   output logic          starved,
   output logic [7:0]    instr_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2
   } state_t;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   state_t        state, state_nxt;
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          empty;
   logic          wr_acc;
   logic          consume;
   logic          complete;

   assign empty    = (count == '0);
   assign full     = (count == FULL_CNT);
   assign busy     = (state != IDLE);
   assign starved  = busy && ext_req && empty;
   assign proc_en  = busy && !starved;
   assign consume  = proc_en && ext_req;
   assign complete = proc_en && clr_in;
   // A full queue refuses the write even if a pop frees a slot this same cycle.
   assign wr_acc   = wr_en && !full;
   assign data_out = empty ? '0 : mem[rd_ptr];

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (stop)       state_nxt = IDLE;
            else if (start) state_nxt = RUN;
            else if (step)  state_nxt = STEP;
         end
         RUN: begin
            if (stop) state_nxt = IDLE;
         end
         STEP: begin
            if (stop)          state_nxt = IDLE;
            else if (complete) state_nxt = IDLE;
            else if (start)    state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         instr_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (wr_acc)
            wr_ptr <= wr_ptr + 1'b1;
         if (consume)
            rd_ptr <= rd_ptr + 1'b1;
         if (wr_acc && !consume)
            count <= count + 1'b1;
         else if (consume && !wr_acc)
            count <= count - 1'b1;
         if (wr_en && full)
            overflow <= 1'b1;
         if (complete)
            instr_cnt <= instr_cnt + 1'b1;
      end
   end

   // Storage carries no reset; empty masks stale contents on data_out.
   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wr_ptr] <= wr_data;
   end

endmodule

// File: tb/tb_ext_sequencer.sv
// Scoreboard bench for ext_sequencer: queued words are pushed on write and popped on each Ext consume.
module tb_ext_sequencer;

   localparam int W = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr_en = 1'b0;
   logic [W-1:0]  wr_data = '0;
   logic          full;
   logic [4:0]    count;
   logic          overflow;
   logic          start = 1'b0;
   logic          step = 1'b0;
   logic          stop = 1'b0;
   logic          ext_req = 1'b0;
   logic          clr_in = 1'b0;
   logic [W-1:0]  data_out;
   logic          proc_en;
   logic          busy;
   logic          starved;
   logic [7:0]    instr_cnt;

   int            checks = 0;
   int            failures = 0;
   logic [W-1:0]  sb [$];
   int            exp_icnt = 0;
   logic          exp_ovf = 1'b0;

   ext_sequencer #(.DEPTH(16), .AW(4), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .full      (full),
      .count     (count),
      .overflow  (overflow),
      .start     (start),
      .step      (step),
      .stop      (stop),
      .ext_req   (ext_req),
      .clr_in    (clr_in),
      .data_out  (data_out),
      .proc_en   (proc_en),
      .busy      (busy),
      .starved   (starved),
      .instr_cnt (instr_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      exp_icnt = 0;
      exp_ovf  = 1'b0;
   endtask

   task automatic host_write(input logic [W-1:0] w);
      wr_en   = 1'b1;
      wr_data = w;
      if (sb.size() < 16) sb.push_back(w);
      else exp_ovf = 1'b1;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic cmd(input int which);
      start = (which == 0);
      step  = (which == 1);
      stop  = (which == 2);
      tick();
      start = 1'b0;
      step  = 1'b0;
      stop  = 1'b0;
   endtask

   // One processor timestep: drive Ext/Clr, check enable and the popped word.
   task automatic proc_cycle(input logic ext, input logic clr, input logic exp_pe);
      logic [W-1:0] exp_w;
      ext_req = ext;
      clr_in  = clr;
      #1;
      chk("proc_en", proc_en, exp_pe);
      if (exp_pe && ext) begin
         exp_w = (sb.size() > 0) ? sb.pop_front() : '0;
         chk("data_out", data_out, exp_w);
      end
      if (exp_pe && clr) exp_icnt++;
      @(posedge clk);
      #1;
      ext_req = 1'b0;
      clr_in  = 1'b0;
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_count", count, 0);
      chk("rst_full", full, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_busy", busy, 0);
      chk("rst_proc_en", proc_en, 0);
      chk("rst_starved", starved, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_instr_cnt", instr_cnt, 0);

      // LOAD + ADDI program in continuous run
      host_write(10'h002);
      host_write(10'h0C0);
      host_write(10'h2A5);
      chk("prog_count3", count, sb.size());
      chk("prog_head", data_out, 10'h002);
      cmd(0);
      chk("prog_busy", busy, 1);
      proc_cycle(1'b1, 1'b0, 1'b1);
      proc_cycle(1'b1, 1'b1, 1'b1);
      proc_cycle(1'b1, 1'b0, 1'b1);
      proc_cycle(1'b0, 1'b0, 1'b1);
      proc_cycle(1'b0, 1'b0, 1'b1);
      proc_cycle(1'b0, 1'b1, 1'b1);
      chk("prog_count0", count, 0);
      chk("prog_instr_cnt", instr_cnt, exp_icnt);
      chk("prog_proc_en", proc_en, 1);
      cmd(2);
      chk("prog_stopped", busy, 0);

      // Fill past capacity, then drain in order
      reset_dut();
      for (int i = 0; i < 17; i++) begin
         host_write(W'(i));
         if (i == 15) begin
            chk("fill_full", full, 1);
            chk("fill_count16", count, 16);
            chk("fill_no_ovf", overflow, 0);
         end
      end
      chk("fill_overflow", overflow, exp_ovf);
      chk("fill_count_after17", count, 16);
      cmd(0);
      for (int i = 0; i < 16; i++)
         proc_cycle(1'b1, 1'b0, 1'b1);
      chk("drain_count", count, 0);
      chk("drain_full", full, 0);
      chk("drain_rd_ptr", dut.rd_ptr, 0);
      cmd(2);

      // Starvation until a word arrives
      reset_dut();
      cmd(0);
      ext_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("starve_starved", starved, 1);
         chk("starve_proc_en", proc_en, 0);
         tick();
      end
      wr_en   = 1'b1;
      wr_data = 10'h012;
      sb.push_back(10'h012);
      #1;
      chk("starve_write_cycle_pe", proc_en, 0);
      tick();
      wr_en = 1'b0;
      #1;
      chk("starve_resume_pe", proc_en, 1);
      chk("starve_resume_starved", starved, 0);
      chk("starve_resume_data", data_out, sb.pop_front());
      tick();
      ext_req = 1'b0;
      #1;
      chk("starve_count", count, 0);

      // Single-step one ADD
      cmd(2);
      host_write(10'h012);
      host_write(10'h062);
      cmd(1);
      chk("step_busy", busy, 1);
      proc_cycle(1'b1, 1'b0, 1'b1);
      proc_cycle(1'b0, 1'b0, 1'b1);
      proc_cycle(1'b0, 1'b0, 1'b1);
      proc_cycle(1'b0, 1'b1, 1'b1);
      chk("step_idle", busy, 0);
      chk("step_proc_en", proc_en, 0);
      chk("step_instr_cnt", instr_cnt, exp_icnt);
      chk("step_count", count, sb.size());
      chk("step_head", data_out, 10'h062);

      // Pause during T2, resume and finish T3
      cmd(0);
      proc_cycle(1'b1, 1'b0, 1'b1);
      proc_cycle(1'b0, 1'b0, 1'b1);
      stop = 1'b1;
      proc_cycle(1'b0, 1'b0, 1'b1);
      stop = 1'b0;
      proc_cycle(1'b0, 1'b0, 1'b0);
      proc_cycle(1'b0, 1'b0, 1'b0);
      chk("pause_busy", busy, 0);
      cmd(0);
      proc_cycle(1'b0, 1'b1, 1'b1);
      chk("resume_instr_cnt", instr_cnt, exp_icnt);
      chk("resume_count", count, 0);

      // Reset mid-instruction with words queued
      for (int i = 0; i < 6; i++)
         host_write(W'(10'h100 + i));
      proc_cycle(1'b1, 1'b0, 1'b1);
      chk("mid_count5", count, 5);
      rst     = 1'b1;
      ext_req = 1'b1;
      tick();
      rst     = 1'b0;
      ext_req = 1'b0;
      sb.delete();
      exp_icnt = 0;
      #1;
      chk("mid_rst_count", count, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_proc_en", proc_en, 0);
      chk("mid_rst_instr_cnt", instr_cnt, exp_icnt);
      chk("mid_rst_overflow", overflow, 0);
      chk("mid_rst_data_out", data_out, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
